inst_fetch: RTL

- Program-memory fetch stage directly upstream of the decode/inst_buffer path.
- Reads the byte-wide program ROM and assembles variable-length instructions of 1–4 bytes into a 32-bit word.
- Presents each assembled word with its PC over a valid/stall handshake to the decoder, which in turn feeds the instruction buffer.
- Handles jump redirection by flushing in-flight state.

---
 rtl/inst_fetch.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   Program-memory fetch stage. Reads the byte-wide program ROM one byte per
//   cycle, assembles variable-length instructions (1..4 bytes, length taken
//   from opcode[7:6]) into a 32-bit word and presents it, with the address of
//   its opcode byte, to the decoder over a valid/stall handshake. A jump
//   request flushes all in-flight state and restarts fetching at the target.
//
// Ports
//   clk_i         system clock, rising edge
//   rst_i         synchronous reset, active low
//   rom_en_o      ROM read strobe (data returns on rom_data_i next cycle)
//   rom_addr_o    ROM read address (the fetch pointer)
//   rom_data_i    ROM read data
//   stall_i       downstream cannot accept; output is held
//   jump_i        one-cycle redirect request
//   jump_addr_i   redirect target
//   inst_valid_o  inst_o / inst_pc_o / inst_len_o hold a complete instruction
//   inst_o        {opcode, byte1, byte2, byte3}, unused trailing bytes zero
//   inst_pc_o     address of the opcode byte
//   inst_len_o    instruction length minus one
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              rom_en_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [7:0]        rom_data_i,
  input  logic              stall_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  output logic              inst_valid_o,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic [1:0]        inst_len_o
);

  typedef enum logic [1:0] {S_ISSUE, S_OP, S_OPND, S_FULL} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_fptr;
  logic [ADDR_W-1:0] r_opc_pc;
  logic [1:0]        r_cnt;
  logic [1:0]        r_len;
  logic [31:0]       r_buf;
  logic              r_valid;
  logic [31:0]       r_inst;
  logic [ADDR_W-1:0] r_pc;
  logic [1:0]        r_ilen;

  logic              w_load_ok;
  logic              w_done;
  logic              w_issue;
  logic              w_load;
  logic              w_rom_en;
  logic [31:0]       w_asm;
  logic [1:0]        w_asm_len;

  // The output register can take a new word if it is empty or being consumed.
  assign w_load_ok = !r_valid || !stall_i;

  // Merge the byte returning this cycle into the assembly word and decide
  // whether the instruction is complete or another byte must be read.
  always_comb begin
    w_asm     = r_buf;
    w_asm_len = r_len;
    w_done    = 1'b0;
    w_issue   = 1'b0;
    case (r_state)
      S_ISSUE: w_issue = 1'b1;
      S_OP: begin
        // Opcode byte: clears the trailing bytes of any previous instruction.
        w_asm     = {rom_data_i, 24'h000000};
        w_asm_len = rom_data_i[7:6];
        if (rom_data_i[7:6] == 2'd0) w_done  = 1'b1;
        else                         w_issue = 1'b1;
      end
      S_OPND: begin
        case (r_cnt)
          2'd1:    w_asm[23:16] = rom_data_i;
          2'd2:    w_asm[15:8]  = rom_data_i;
          2'd3:    w_asm[7:0]   = rom_data_i;
          default: w_asm        = r_buf;
        endcase
        if (r_cnt == r_len) w_done  = 1'b1;
        else                w_issue = 1'b1;
      end
      default: ;
    endcase
  end

  // A completed (or parked) word moves to the output only when there is room;
  // the next opcode read is issued in the same cycle so fetch never bubbles.
  assign w_load   = (w_done || (r_state == S_FULL)) && w_load_ok;
  assign w_rom_en = rst_i && !jump_i && (w_issue || w_load);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state  <= S_ISSUE;
      r_fptr   <= RESET_PC;
      r_opc_pc <= RESET_PC;
      r_cnt    <= 2'd0;
      r_len    <= 2'd0;
      r_buf    <= 32'h0;
      r_valid  <= 1'b0;
      r_inst   <= 32'h0;
      r_pc     <= '0;
      r_ilen   <= 2'd0;
    end else if (jump_i) begin
      // Redirect: drop the output, the partial word and the pending read.
      r_state <= S_ISSUE;
      r_fptr  <= jump_addr_i;
      r_cnt   <= 2'd0;
      r_buf   <= 32'h0;
      r_valid <= 1'b0;
    end else begin
      if (w_rom_en) r_fptr <= r_fptr + 1'b1;

      if (w_load) begin
        r_valid <= 1'b1;
        r_inst  <= w_asm;
        r_pc    <= r_opc_pc;
        r_ilen  <= w_asm_len;
      end else if (r_valid && !stall_i) begin
        r_valid <= 1'b0;
      end

      if (r_state == S_OP || r_state == S_OPND) begin
        r_buf <= w_asm;
        r_len <= w_asm_len;
      end

      case (r_state)
        S_ISSUE: begin
          r_opc_pc <= r_fptr;
          r_state  <= S_OP;
        end
        S_OP, S_OPND, S_FULL: begin
          if (w_load) begin
            r_opc_pc <= r_fptr;
            r_state  <= S_OP;
          end else if (w_done) begin
            r_state <= S_FULL;
          end else if (r_state == S_OP) begin
            r_cnt   <= 2'd1;
            r_state <= S_OPND;
          end else if (r_state == S_OPND) begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        default: r_state <= S_ISSUE;
      endcase
    end
  end

  assign rom_en_o     = w_rom_en;
  assign rom_addr_o   = r_fptr;
  assign inst_valid_o = r_valid;
  assign inst_o       = r_inst;
  assign inst_pc_o    = r_pc;
  assign inst_len_o   = r_ilen;

endmodule
